// File: rtl/os_ctrl_pkg.sv
// Shared types and sizing helpers for the output-stationary array sequencer.
package os_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int calc_rw(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int calc_cnt_w(
        input int k_w,
        input int rows,
        input int cols,
        input int stage
    );
        return k_w + $clog2(rows + cols + stage) + 1;
    endfunction

    // Cycles for the last operand to ripple through skew and multiplier.
    function automatic logic [63:0] total_cycles(
        input logic [63:0] k,
        input int          rows,
        input int          cols,
        input int          stage
    );
        return k + 64'(rows + cols - 2 + stage);
    endfunction

endpackage

// File: rtl/os_drain_sequencer.sv
// Row counter for draining stationary results over a valid/ready handshake.
module os_drain_sequencer #(
    parameter int ROWS = 4,
    parameter int RW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          drain_ready,
    output logic          drain_valid,
    output logic [RW-1:0] drain_row,
    output logic          last_row
);

    logic [RW-1:0] row_q, row_d;

    assign drain_valid = en;
    assign drain_row   = row_q;
    assign last_row    = (row_q == RW'(ROWS - 1));

    always_comb begin
        row_d = row_q;
        if (clr) begin
            row_d = '0;
        end else if (en && drain_ready) begin
            row_d = last_row ? '0 : row_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/os_array_controller.sv
// Clear / compute / drain sequencer for the output-stationary systolic array.
module os_array_controller
    import os_ctrl_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_W   = 16,
    parameter int STAGE = 0,
    parameter int RW    = calc_rw(ROWS),
    parameter int CNT_W = calc_cnt_w(K_W, ROWS, COLS, STAGE)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    input  logic           stall,
    input  logic           abort,
    output logic           feed_en,
    output logic           pipeline_en,
    output logic           reg_clear,
    output logic           mac_end,
    output logic           drain_valid,
    output logic [RW-1:0]  drain_row,
    input  logic           drain_ready,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] total;
    logic [K_W-1:0]   k_len_q, k_len_d;
    logic             reg_clear_q, reg_clear_d;
    logic             mac_end_q, mac_end_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             last_row;
    logic             abort_act;

    assign total = CNT_W'(total_cycles(64'(k_len_q), ROWS, COLS, STAGE));

    assign abort_act   = abort && (state_q != ST_IDLE);
    assign pipeline_en = (state_q == ST_COMPUTE) && !stall;
    assign feed_en     = pipeline_en && (cnt_q < CNT_W'(k_len_q));

    assign reg_clear = reg_clear_q;
    assign mac_end   = mac_end_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    os_drain_sequencer #(
        .ROWS (ROWS),
        .RW   (RW)
    ) u_drain (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (mac_end_q),
        .clr         (abort_act),
        .drain_ready (drain_ready),
        .drain_valid (drain_valid),
        .drain_row   (drain_row),
        .last_row    (last_row)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_len_d     = k_len_q;
        reg_clear_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (k_len != '0)) begin
                    k_len_d     = k_len;
                    reg_clear_d = 1'b1;
                    state_d     = ST_CLEAR;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (pipeline_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == total - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_valid && drain_ready && last_row) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wipes the partial accumulators on its way back to idle.
        if (abort_act) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            reg_clear_d = 1'b1;
            done_d      = 1'b0;
        end

        mac_end_d = (state_d == ST_DRAIN);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_len_q     <= '0;
            reg_clear_q <= 1'b0;
            mac_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_len_q     <= k_len_d;
            reg_clear_q <= reg_clear_d;
            mac_end_q   <= mac_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_os_array_controller.sv
// Table-driven and randomized bench for os_array_controller.
module tb_os_array_controller;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int K_W   = 16;
    localparam int STAGE = 0;
    localparam int RW    = 2;

    logic           clk;
    logic           rst_n;
    logic           start_i;
    logic [K_W-1:0] k_len_i;
    logic           stall_i;
    logic           abort_i;
    logic           ready_i;
    logic           feed_en;
    logic           pipeline_en;
    logic           reg_clear;
    logic           mac_end;
    logic           drain_valid;
    logic [RW-1:0]  drain_row;
    logic           busy;
    logic           done;
    logic           err;

    int total;
    int bad;

    bit stall_a[512];
    bit rdy_a[64];

    typedef struct {
        int k;
        int st_at;
        int st_len;
        int rl_at;
        int rl_len;
        int poke;
        int exp_pe;
        int exp_feed;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    os_array_controller #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .K_W   (K_W),
        .STAGE (STAGE),
        .RW    (RW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_i),
        .k_len       (k_len_i),
        .stall       (stall_i),
        .abort       (abort_i),
        .feed_en     (feed_en),
        .pipeline_en (pipeline_en),
        .reg_clear   (reg_clear),
        .mac_end     (mac_end),
        .drain_valid (drain_valid),
        .drain_row   (drain_row),
        .drain_ready (ready_i),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".pipeline_en"}, int'(pipeline_en), 0);
        chk({nm, ".feed_en"}, int'(feed_en), 0);
        chk({nm, ".reg_clear"}, int'(reg_clear), 0);
        chk({nm, ".mac_end"}, int'(mac_end), 0);
        chk({nm, ".drain_valid"}, int'(drain_valid), 0);
        chk({nm, ".drain_row"}, int'(drain_row), 0);
        chk({nm, ".busy"}, int'(busy), 0);
        chk({nm, ".done"}, int'(done), 0);
        chk({nm, ".err"}, int'(err), 0);
    endtask

    task automatic set_stim(input int st_at, input int st_len,
                            input int rl_at, input int rl_len);
        for (int i = 0; i < 512; i++) stall_a[i] = (i >= st_at) && (i < st_at + st_len);
        for (int i = 0; i < 64; i++) rdy_a[i] = !((i >= rl_at) && (i < rl_at + rl_len));
    endtask

    // Call at negedge+1 with the DUT idle; start is sampled on the next edge.
    task automatic run_core(input int k, input int poke_c,
                            output int pe_n, output int feed_n, output int done_c);
        int t, c_last, dn, seen, rows_acc, exp_done, m_pe_n, d;
        bit fin, exp_pe, in_drain;
        t = k + ROWS + COLS - 2 + STAGE;
        seen = 0;
        c_last = 1;
        while (seen < t && c_last < 510) begin
            c_last++;
            if (!stall_a[c_last]) seen++;
        end
        rows_acc = 0;
        dn = 0;
        while (rows_acc < ROWS && dn < 64) begin
            if (rdy_a[dn]) rows_acc++;
            dn++;
        end
        exp_done = c_last + 1 + dn;

        pe_n = 0;
        feed_n = 0;
        done_c = -1;
        m_pe_n = 0;
        rows_acc = 0;
        fin = 1'b0;
        k_len_i = K_W'(k);
        start_i = 1'b1;
        for (int c = 1; c < 400 && !fin; c++) begin
            @(negedge clk);
            start_i = (c == poke_c);
            if (start_i) k_len_i = K_W'(30);
            stall_i = (c < 512) ? stall_a[c] : 1'b0;
            d = c - c_last - 1;
            in_drain = (c > c_last) && (c < exp_done);
            ready_i = (d >= 0 && d < 64) ? rdy_a[d] : 1'b1;
            #1;
            exp_pe = (c >= 2) && (c <= c_last) && !stall_i;
            chk("pipeline_en", int'(pipeline_en), int'(exp_pe));
            chk("feed_en", int'(feed_en), int'(exp_pe && m_pe_n < k));
            if (exp_pe) m_pe_n++;
            if (pipeline_en) pe_n++;
            if (feed_en) feed_n++;
            chk("reg_clear", int'(reg_clear), int'(c == 1));
            chk("drain_valid", int'(drain_valid), int'(in_drain));
            chk("mac_end", int'(mac_end), int'(in_drain));
            if (in_drain) begin
                chk("drain_row", int'(drain_row), rows_acc);
                if (ready_i) rows_acc++;
            end
            chk("done", int'(done), int'(c == exp_done));
            chk("busy", int'(busy), int'(c <= exp_done));
            chk("err", int'(err), 0);
            if (done) done_c = c;
            if (c > exp_done) fin = 1'b1;
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        ready_i = 1'b1;
        if (!fin) chk("run_timeout", 0, 1);
    endtask

    initial begin
        int pe, fd, dc, k;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        abort_i = 1'b0;
        ready_i = 1'b1;
        k_len_i = '0;
        #2;
        chk_quiet("reset");
        #10 rst_n = 1'b1;
        @(negedge clk);
        #1;

        vecs[0] = '{8, 0, 0, 0, 0, 0, 14, 8, 20};
        vecs[1] = '{8, 3, 3, 0, 0, 0, 14, 8, 23};
        vecs[2] = '{8, 0, 0, 1, 5, 0, 14, 8, 25};
        vecs[3] = '{1, 0, 0, 0, 0, 4, 7, 1, 13};
        vecs[4] = '{3, 2, 2, 0, 0, 0, 9, 3, 17};
        vecs[5] = '{2, 0, 0, 3, 2, 0, 8, 2, 16};
        vecs[6] = '{20, 12, 4, 0, 1, 9, 26, 20, 37};
        for (int i = 0; i < 7; i++) begin
            set_stim(vecs[i].st_at, vecs[i].st_len, vecs[i].rl_at, vecs[i].rl_len);
            run_core(vecs[i].k, vecs[i].poke, pe, fd, dc);
            chk("vec_pe_total", pe, vecs[i].exp_pe);
            chk("vec_feed_total", fd, vecs[i].exp_feed);
            chk("vec_done_cycle", dc, vecs[i].exp_done);
        end

        // zero-depth command only flags an error
        start_i = 1'b1;
        k_len_i = '0;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("zero_k.err", int'(err), 1);
        chk("zero_k.busy", int'(busy), 0);
        chk("zero_k.reg_clear", int'(reg_clear), 0);
        @(negedge clk);
        #1;
        chk("zero_k.err_pulse", int'(err), 0);
        chk("zero_k.busy_after", int'(busy), 0);

        // abort while cnt == 5
        set_stim(0, 0, 0, 0);
        k_len_i = K_W'(8);
        start_i = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            abort_i = (c == 7);
            #1;
            chk("abort.no_done", int'(done), 0);
            if (c == 7) chk("abort.busy_before", int'(busy), 1);
        end
        chk("abort.reg_clear", int'(reg_clear), 1);
        chk("abort.busy", int'(busy), 0);
        chk("abort.mac_end", int'(mac_end), 0);
        chk("abort.pipeline_en", int'(pipeline_en), 0);
        run_core(4, 0, pe, fd, dc);
        chk("after_abort.pe", pe, 10);
        chk("after_abort.done", dc, 16);

        // randomized runs against the arithmetic model
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(1, 40));
            for (int i = 0; i < 512; i++) stall_a[i] = (i < 256) && ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++) rdy_a[i] = (i >= 32) || ($urandom_range(0, 2) != 0);
            run_core(k, 0, pe, fd, dc);
            chk("rand.pe_total", pe, k + ROWS + COLS - 2 + STAGE);
            chk("rand.feed_total", fd, k);
        end

        // asynchronous reset in the middle of draining
        set_stim(0, 0, 0, 0);
        k_len_i = K_W'(8);
        start_i = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
        end
        chk("mid_drain.valid", int'(drain_valid), 1);
        chk("mid_drain.row", int'(drain_row), 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_core(1, 0, pe, fd, dc);
        chk("post_reset.pe", pe, 7);
        chk("post_reset.feed", fd, 1);
        chk("post_reset.done", dc, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/os_array_controller.md
# os_array_controller

Sequencer for the output-stationary systolic array built from `processing_element_os` tiles. It clears the array, then drives the shared `pipeline_en` for exactly enough cycles for a K-deep operand stream, including array skew and multiplier pipeline, to finish accumulating. It then holds `mac_end` while draining the stationary results one row at a time over a valid/ready handshake. It sits between the layer-level command interface and the array, next to the edge skew buffers it paces via `feed_en`.

## Interface
Parameters:
- ROWS, 4, array rows (≥1)
- COLS, 4, array columns (≥1)
- K_W, 16, width of the reduction-depth field
- STAGE, 0, multiplier pipeline stages inside each PE
- RW, $clog2(ROWS) (min 1), drain row index width
- CNT_W, K_W+$clog2(ROWS+COLS+STAGE)+1, compute counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command strobe, sampled only in IDLE
- k_len  in  K_W  reduction depth, captured on accepted start
- stall  in  1  edge buffers empty; freezes compute
- abort  in  1  synchronous abort, any state
- feed_en  out  1  skew buffers push next k-slice this cycle
- pipeline_en  out  1  to every PE pipeline_en/cell_en
- reg_clear  out  1  to every PE reg_clear
- mac_end  out  1  to every PE mac_end (freeze accumulators, expose MAC_out)
- drain_valid  out  1  drain_row results valid on array MAC_out bus
- drain_row  out  RW  row being drained
- drain_ready  in  1  consumer accepts row
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: start with k_len==0

## Operation
- States: IDLE, CLEAR, COMPUTE, DRAIN, DONE; encoding in package.
- IDLE: start&&k_len≠0 latches k_len → CLEAR; start&&k_len==0 → err pulse, stay IDLE.
- CLEAR: reg_clear=1 for one cycle; cnt←0 → COMPUTE.
- COMPUTE: pipeline_en = ~stall. cnt increments on every pipeline_en cycle. feed_en = pipeline_en && cnt < k_len_q. TOTAL = k_len_q + ROWS + COLS − 2 + STAGE. Leave for DRAIN when pipeline_en && cnt == TOTAL−1.
- DRAIN: mac_end=1, drain_valid=1, drain_row=row. Row advances on drain_valid&&drain_ready. Handshake on row ROWS−1 → DONE. drain_row and the MAC_out bus stay stable while ready is low.
- DONE: done=1 for one cycle → IDLE. mac_end=0.
- abort (highest priority, any non-IDLE state): next state IDLE, reg_clear=1 for that single cycle, cnt/row←0, no done. Abort in IDLE has no effect.
- start while busy is ignored.
- TOTAL is computed at CNT_W width with no overflow for k_len=2^K_W−1.

## Timing
- Reset: state IDLE. All outputs 0, drain_row 0. cnt, row, k_len_q all 0.
- All outputs are registered-state decodes (Moore); no combinational input→output path except pipeline_en/feed_en from stall and state advance from drain_ready.
- Accepted start at edge t: reg_clear high in cycle t+1; first pipeline_en cycle t+2 if stall=0.
- No stalls: COMPUTE lasts TOTAL cycles, first row valid TOTAL+2 cycles after start. done comes ROWS cycles later with ready held high.
- Stall cycles extend COMPUTE one-for-one; feed_en never asserts during stall.
- done and busy fall together: busy=0 the cycle after done.

## Structure
- Package os_ctrl_pkg: state enum, a TOTAL computation function, CNT_W/RW derivation helpers, shared with the array top.
- One sub-module, os_drain_sequencer: row counter plus valid/ready handshake, with an enable from the FSM and a last-row flag back to it.

## Test plan
- ROWS=COLS=4, STAGE=0, k_len=8, no stall, ready=1 → reg_clear 1 cycle, pipeline_en 14 cycles, feed_en first 8 of them, drain_row 0..3 over 4 cycles, done one cycle later.
- Same config, stall high for 3 cycles in COMPUTE cycles 2–4 → pipeline_en totals 14, feed_en totals 8, done 3 cycles later than baseline.
- In DRAIN, drain_ready low for 5 cycles on row 1 → drain_row holds 1, mac_end stays high, row 2 follows the first ready.
- abort at COMPUTE cnt=5 → next cycle IDLE with reg_clear=1, busy=0, done never pulses; a new start is accepted 1 cycle later.
- start with k_len=0 → err pulse only, busy stays 0. start during busy is ignored, with k_len_q unchanged.
- rst_n asserted mid-DRAIN → all outputs 0 asynchronously; after release, a new k_len=1 run gives TOTAL=7 with STAGE=0.
